// File: rtl/axi_rd_pkg.sv
// ============================================================================
// axi_rd_pkg : shared types and constants for the AXI read-channel arbiter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package axi_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic       REQ_IF          = 1'b0;
    localparam logic       REQ_LS          = 1'b1;
    localparam logic [1:0] RRESP_OKAY      = 2'b00;
    localparam logic [2:0] IF_PROT_DEFAULT = 3'b110;
    localparam logic [2:0] LS_PROT_DEFAULT = 3'b010;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2  : two-input round-robin picker (combinational only)
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import axi_rd_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_IF;
        // On a tie the requester that did not win last time gets the port.
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else if (req[REQ_LS]) begin
            gnt_id = REQ_LS;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// axi_rd_arbiter : shares one AXI read port between IF and LS, one transaction
//                  per grant, returning the last beat and an accumulated error.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 64,
    parameter logic [2:0] IF_PROT = IF_PROT_DEFAULT,
    parameter logic [2:0] LS_PROT = LS_PROT_DEFAULT
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              ARVALID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [2:0]        ARPROT,
    input  logic              ARREADY,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic              RLAST,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP
);

    state_t state;
    state_t state_nxt;
    logic   owner;
    logic   last_grant;
    logic   err_acc;
    logic   gnt_valid;
    logic   gnt_id;
    logic   beat_err;

    rr_arb2 u_rr_arb2 (
        .req        ({ls_req, if_req}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign beat_err = (RRESP != RRESP_OKAY);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (gnt_valid)        state_nxt = ST_ADDR;
            ST_ADDR: if (ARREADY)          state_nxt = ST_DATA;
            ST_DATA: if (RVALID && RLAST)  state_nxt = ST_RESP;
            ST_RESP:                       state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            owner      <= REQ_IF;
            last_grant <= REQ_IF;
            err_acc    <= 1'b0;
            ARADDR     <= '0;
            ARPROT     <= 3'b000;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            ls_rdata   <= '0;
            ls_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        owner      <= gnt_id;
                        last_grant <= gnt_id;
                        err_acc    <= 1'b0;
                        ARADDR     <= (gnt_id == REQ_LS) ? ls_addr : if_addr;
                        ARPROT     <= (gnt_id == REQ_LS) ? LS_PROT : IF_PROT;
                    end
                end
                ST_DATA: begin
                    if (RVALID) begin
                        if (RLAST) begin
                            if (owner == REQ_LS) begin
                                ls_rdata <= RDATA;
                                ls_err   <= err_acc | beat_err;
                            end else begin
                                if_rdata <= RDATA;
                                if_err   <= err_acc | beat_err;
                            end
                        end else begin
                            // Earlier beats only contribute their error status.
                            err_acc <= err_acc | beat_err;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ARVALID  = (state == ST_ADDR);
    assign RREADY   = (state == ST_DATA);
    assign if_valid = (state == ST_RESP) && (owner == REQ_IF);
    assign ls_valid = (state == ST_RESP) && (owner == REQ_LS);

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// tb_axi_rd_arbiter : randomized requesters and memory slave checked against
//                     a transaction-level reference model.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_axi_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int N_CYC  = 4000;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              if_req, ls_req;
    logic [ADDR_W-1:0] if_addr, ls_addr;
    logic              if_valid, ls_valid, if_err, ls_err;
    logic [DATA_W-1:0] if_rdata, ls_rdata;
    logic              ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;

    axi_rd_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IF_PROT(3'b110),
        .LS_PROT(3'b010)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_valid(if_valid),
        .if_rdata(if_rdata),
        .if_err  (if_err),
        .ls_req  (ls_req),
        .ls_addr (ls_addr),
        .ls_valid(ls_valid),
        .ls_rdata(ls_rdata),
        .ls_err  (ls_err),
        .ARVALID (ARVALID),
        .ARADDR  (ARADDR),
        .ARPROT  (ARPROT),
        .ARREADY (ARREADY),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RLAST   (RLAST),
        .RDATA   (RDATA),
        .RRESP   (RRESP)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: which requester owns the port and how far
    // its single transaction has progressed.
    bit          m_busy, m_addr_done, m_final, m_owner, m_last, m_acc;
    int          m_beats_left;
    logic [63:0] m_rdata [2];
    bit          m_err   [2];
    bit          seen_valid [2];
    bit          req_q  [2];
    logic [31:0] addr_q [2];
    int          n_done_model, n_done_dut;

    function automatic bit pick(bit i, bit l, bit last);
        if (i && l) return ~last;
        return l;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_addr_done = 0; m_final = 0; m_owner = 0; m_last = 0; m_acc = 0;
        m_beats_left = 0;
        for (int r = 0; r < 2; r++) begin
            m_rdata[r] = '0; m_err[r] = 0; seen_valid[r] = 0; req_q[r] = 0;
        end
    endtask

    task automatic sample_and_step();
        bit exp_arv, exp_rr, eb;
        exp_arv = m_busy && !m_addr_done;
        exp_rr  = m_busy && m_addr_done && !m_final;
        check("arvalid",  64'(ARVALID),  64'(exp_arv));
        check("rready",   64'(RREADY),   64'(exp_rr));
        check("if_valid", 64'(if_valid), 64'(m_final && !m_owner));
        check("ls_valid", 64'(ls_valid), 64'(m_final && m_owner));
        if (exp_arv) begin
            check("araddr", 64'(ARADDR), 64'(m_owner ? ls_addr : if_addr));
            check("arprot", 64'(ARPROT), 64'(m_owner ? 3'b010 : 3'b110));
        end
        check("if_rdata", if_rdata,     m_rdata[0]);
        check("if_err",   64'(if_err),  64'(m_err[0]));
        check("ls_rdata", ls_rdata,     m_rdata[1]);
        check("ls_err",   64'(ls_err),  64'(m_err[1]));
        if (if_valid || ls_valid) n_done_dut++;

        if (m_final) begin
            seen_valid[m_owner] = 1;
            n_done_model++;
            m_busy  = 0;
            m_final = 0;
        end else if (!m_busy) begin
            if (if_req || ls_req) begin
                m_owner     = pick(if_req, ls_req, m_last);
                m_last      = m_owner;
                m_busy      = 1;
                m_addr_done = 0;
                m_acc       = 0;
            end
        end else if (!m_addr_done) begin
            if (ARREADY) begin
                m_addr_done  = 1;
                m_beats_left = $urandom_range(1, 4);
            end
        end else if (RVALID) begin
            eb = (RRESP != 2'b00);
            if (RLAST) begin
                m_rdata[m_owner] = RDATA;
                m_err[m_owner]   = m_acc | eb;
                m_final          = 1;
            end else begin
                m_acc = m_acc | eb;
            end
            m_beats_left--;
        end
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < 2; r++) begin
            if (req_q[r] && seen_valid[r]) begin
                if ($urandom_range(0, 3) == 0) addr_q[r] = $urandom;
                else                           req_q[r]  = 0;
            end else if (!req_q[r] && $urandom_range(0, 2) == 0) begin
                req_q[r]  = 1;
                addr_q[r] = $urandom;
            end
            seen_valid[r] = 0;
        end
        if_req = req_q[0]; if_addr = addr_q[0];
        ls_req = req_q[1]; ls_addr = addr_q[1];
    endtask

    task automatic drive_slave();
        ARREADY = ($urandom_range(0, 1) == 0);
        RVALID  = ($urandom_range(0, 2) != 0);
        RDATA   = {$urandom, $urandom};
        RRESP   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (m_busy && m_addr_done && !m_final) RLAST = (m_beats_left == 1);
        else                                   RLAST = ($urandom_range(0, 1) == 0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_arvalid"}, 64'(ARVALID),  64'd0);
        check({pfx, "_rready"},  64'(RREADY),   64'd0);
        check({pfx, "_araddr"},  64'(ARADDR),   64'd0);
        check({pfx, "_arprot"},  64'(ARPROT),   64'd0);
        check({pfx, "_ifvalid"}, 64'(if_valid), 64'd0);
        check({pfx, "_lsvalid"}, 64'(ls_valid), 64'd0);
        check({pfx, "_ifrdata"}, if_rdata,      64'd0);
        check({pfx, "_lsrdata"}, ls_rdata,      64'd0);
        check({pfx, "_iferr"},   64'(if_err),   64'd0);
        check({pfx, "_lserr"},   64'(ls_err),   64'd0);
    endtask

    bit rst_done;

    initial begin
        ARESET = 1'b1;
        if_req = 0; ls_req = 0; if_addr = '0; ls_addr = '0;
        ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0; RRESP = '0;
        n_done_model = 0; n_done_dut = 0; rst_done = 0;
        model_reset();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_reset_values("reset");
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        // Both requesters raise together first: the tie must go to LS.
        req_q[0] = 1; addr_q[0] = 32'h8000_0000;
        req_q[1] = 1; addr_q[1] = 32'h4000_1000;
        if_req = 1; if_addr = addr_q[0];
        ls_req = 1; ls_addr = addr_q[1];
        drive_slave();

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge ACLK);
            sample_and_step();
            @(posedge ACLK);
            #1;
            drive_reqs();
            drive_slave();
            if (!rst_done && cyc > N_CYC / 2 && m_busy && m_addr_done && !m_final && RVALID) begin
                #2;
                ARESET = 1'b1;
                #1;
                check_reset_values("midrst");
                model_reset();
                if_req = 0; ls_req = 0;
                @(posedge ACLK);
                #1;
                ARESET   = 1'b0;
                rst_done = 1;
                drive_reqs();
                drive_slave();
            end
        end

        check("reset_injected", 64'(rst_done), 64'd1);
        check("completions", 64'(n_done_dut), 64'(n_done_model));
        check("enough_traffic", 64'(n_done_model > 100), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
